// File: rtl/reg_select_scoreboard_pkg.sv
// Shared CPU definitions for the register-select / scoreboard slice.
// Provides default widths, the instruction field offset helper and the
// opcode enumeration. There are no ports; the other files import this package.
package reg_select_scoreboard_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned NREGS_DEF   = 16;
  localparam int unsigned OP_W_DEF    = 5;
  localparam int unsigned CONST_W_DEF = 18;
  localparam int unsigned SEL_W_DEF   = $clog2(NREGS_DEF);

  // Register fields are packed directly below the opcode.
  // idx 1 = ra, 2 = rb, 3 = rc.
  function automatic int unsigned field_lsb(input int unsigned data_w,
                                            input int unsigned op_w,
                                            input int unsigned sel_w,
                                            input int unsigned idx);
    return data_w - op_w - idx * sel_w;
  endfunction

  localparam int unsigned RA_LSB_DEF = field_lsb(DATA_W_DEF, OP_W_DEF, SEL_W_DEF, 1);
  localparam int unsigned RB_LSB_DEF = field_lsb(DATA_W_DEF, OP_W_DEF, SEL_W_DEF, 2);
  localparam int unsigned RC_LSB_DEF = field_lsb(DATA_W_DEF, OP_W_DEF, SEL_W_DEF, 3);

  typedef enum logic [OP_W_DEF-1:0] {
    OP_NOP  = 5'd0,
    OP_LD   = 5'd1,
    OP_LDR  = 5'd2,
    OP_ST   = 5'd3,
    OP_STR  = 5'd4,
    OP_LA   = 5'd5,
    OP_LAR  = 5'd6,
    OP_BR   = 5'd8,
    OP_BRL  = 5'd9,
    OP_ADD  = 5'd12,
    OP_ADDI = 5'd13,
    OP_SUB  = 5'd14,
    OP_AND  = 5'd20,
    OP_OR   = 5'd22,
    OP_STOP = 5'd31
  } opcode_e;

endpackage

// File: rtl/reg_select_scoreboard_decoder.sv
// onehot_decoder: binary index to one-hot vector.
//   sel    in   SEL_W  binary index
//   onehot out  NREGS  bit sel set, all others clear
module onehot_decoder #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned NREGS = 16
) (
  input  logic [SEL_W-1:0] sel,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_select_scoreboard.sv
// reg_select_scoreboard: instruction register, register-field select logic,
// one-hot register enables and a pending-write scoreboard.
//   clk, rst_n              clock, async active-low reset
//   ir, ir_ld               instruction word and its load strobe
//   gra, grb, grc           pick ra / rb / rc field (priority in that order)
//   r_in, r_out, ba_out     register write / read / base-address read strobes
//   issue                   mark current ra as pending write
//   retire, retire_sel      clear pending write on retire_sel
//   op, c_sign              opcode and sign-extended constant from the IR
//   reg_in, reg_out         one-hot register enables
//   sel                     effective register index
//   busy, hazard            scoreboard and hazard flag for the current IR
//   zero_out                base-address read of R0 (bus forces 0)
module reg_select_scoreboard
  import reg_select_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned CONST_W = CONST_W_DEF,
  localparam int unsigned SEL_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ir,
  input  logic              ir_ld,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              r_in,
  input  logic              r_out,
  input  logic              ba_out,
  input  logic              issue,
  input  logic              retire,
  input  logic [SEL_W-1:0]  retire_sel,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] c_sign,
  output logic [NREGS-1:0]  reg_in,
  output logic [NREGS-1:0]  reg_out,
  output logic [SEL_W-1:0]  sel,
  output logic [NREGS-1:0]  busy,
  output logic              hazard,
  output logic              zero_out
);

  localparam int unsigned RA_LSB = field_lsb(DATA_W, OP_W, SEL_W, 1);
  localparam int unsigned RB_LSB = field_lsb(DATA_W, OP_W, SEL_W, 2);
  localparam int unsigned RC_LSB = field_lsb(DATA_W, OP_W, SEL_W, 3);

  logic [DATA_W-1:0] ir_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_c;
  logic [SEL_W-1:0]  ra, rb, rc;
  logic [NREGS-1:0]  dec;
  logic              any_gr;

  assign op     = ir_q[DATA_W-1 -: OP_W];
  assign ra     = ir_q[RA_LSB +: SEL_W];
  assign rb     = ir_q[RB_LSB +: SEL_W];
  assign rc     = ir_q[RC_LSB +: SEL_W];
  assign c_sign = {{(DATA_W-CONST_W){ir_q[CONST_W-1]}}, ir_q[CONST_W-1:0]};

  assign any_gr = gra | grb | grc;

  always_comb begin
    sel_c = sel_q;
    if (gra)      sel_c = ra;
    else if (grb) sel_c = rb;
    else if (grc) sel_c = rc;
  end

  assign sel = sel_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q  <= '0;
      sel_q <= '0;
    end else begin
      if (ir_ld)  ir_q  <= ir;
      if (any_gr) sel_q <= sel_c;
    end
  end

  // Set is written after clear so that an issue and a retire naming the
  // same register leave it busy; distinct registers both take effect.
  // ra here is from the IR before any same-cycle ir_ld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (retire) busy[retire_sel] <= 1'b0;
      if (issue)  busy[ra]         <= 1'b1;
    end
  end

  assign hazard = busy[ra] | busy[rb] | busy[rc];

  onehot_decoder #(
    .SEL_W(SEL_W),
    .NREGS(NREGS)
  ) u_dec (
    .sel   (sel_c),
    .onehot(dec)
  );

  // A base-address read of R0 yields constant zero instead of the register.
  assign zero_out = ba_out & (sel_c == '0);
  assign reg_in   = r_in ? dec : '0;
  assign reg_out  = (r_out | (ba_out & (sel_c != '0))) ? dec : '0;

endmodule

// File: doc/reg_select_scoreboard.md
REG_SELECT_SCOREBOARD -- requirements
Module: reg_select_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction and constant width.
REQ-002 SHALL have parameter NREGS, default 16: register count, power of two, at least 2; SEL_W = log2(NREGS).
REQ-003 SHALL have parameter OP_W, default 5: opcode field width.
REQ-004 SHALL have parameter CONST_W, default 18: sign-extended constant field width, CONST_W < DATA_W.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  async active-low reset.
REQ-008 ir  in  DATA_W  instruction word from the bus.
REQ-009 ir_ld  in  1  capture ir into the internal IR at the next edge.
REQ-010 gra, grb, grc  in  1 each  select the ra, rb or rc field.
REQ-011 r_in, r_out, ba_out  in  1 each  register write, read and base-address read strobes.
REQ-012 issue  in  1  mark the current ra register as pending write.
REQ-013 retire  in  1  clear the pending write on retire_sel.
REQ-014 retire_sel  in  SEL_W  register being retired.
REQ-015 op  out  OP_W  opcode.
REQ-016 c_sign  out  DATA_W  sign-extended constant.
REQ-017 reg_in, reg_out  out  NREGS  one-hot register enables.
REQ-018 sel  out  SEL_W  effective register index.
REQ-019 busy  out  NREGS  scoreboard of pending writes.
REQ-020 hazard  out  1  the current instruction touches a busy register.
REQ-021 zero_out  out  1  base-address read of R0; the bus driver forces 0.

Function
REQ-022 The IR SHALL load ir when ir_ld is high and hold otherwise; op, c_sign and the fields SHALL come from the IR, never from ir directly.
REQ-023 Field layout: op = IR[DATA_W-1 -: OP_W]; ra = next SEL_W bits below op; rb = next SEL_W bits below ra; rc = next SEL_W bits below rb.
REQ-024 c_sign SHALL be IR[CONST_W-1:0] sign-extended from IR[CONST_W-1].
REQ-025 Effective select priority: gra, then grb, then grc; a lower-priority strobe is ignored when a higher one is high.
REQ-026 When any gr* is high, sel SHALL equal the chosen field combinationally, and sel_q SHALL capture it at the edge.
REQ-027 When no gr* is high, sel SHALL equal sel_q.
REQ-028 reg_in SHALL be the one-hot code of sel when r_in is high, else 0.
REQ-029 reg_out SHALL be the one-hot code of sel when r_out is high, or when ba_out is high and sel != 0; otherwise 0.
REQ-030 zero_out SHALL be high when ba_out is high and sel == 0, regardless of r_out.
REQ-031 issue SHALL set busy[ra] at the next edge.
REQ-032 retire SHALL clear busy[retire_sel] at the next edge.
REQ-033 When issue and retire name the same register in one cycle, busy SHALL stay set.
REQ-034 When issue and retire name different registers, both actions SHALL happen.
REQ-035 hazard SHALL equal busy[ra] | busy[rb] | busy[rc], computed combinationally from the current IR and busy.
REQ-036 An ir_ld and an issue in the same cycle SHALL use ra of the old IR.

Reset
REQ-037 While rst_n is low, IR, sel_q and busy SHALL be 0 immediately, regardless of clk; op, c_sign, sel and hazard are therefore 0, and reg_in, reg_out and zero_out follow their strobes with sel = 0.
REQ-038 Reset asserted mid-operation SHALL discard all pending scoreboard entries.

Structure
REQ-039 Field offsets, default widths and an opcode enum SHALL live in the shared cpu package.
REQ-040 The one-hot decoder SHALL be one parameterised sub-module, onehot_decoder (SEL_W to NREGS), instantiated once and gated by r_in and r_out.

Verification
REQ-041 Reset, then ir=0x19AC8004 with ir_ld=1 -> next cycle op=3, c_sign=0x00008004, hazard=0.
REQ-042 With that IR loaded, each strobe pair SHALL give the enable shown:
- gra=1, r_in=1 -> reg_in=0x0008
- grb=1, r_out=1 -> reg_out=0x0020
- grc=1, r_out=1 -> reg_out=0x0200
- gra and grc together -> sel=3
REQ-043 ir=0x0003FFFF loaded -> c_sign=0xFFFFFFFF; then gra=1, ba_out=1 (ra=0) -> reg_out=0, zero_out=1.
REQ-044 IR 0x19AC8004, issue=1 -> busy=0x0008, hazard=1; retire with retire_sel=3 -> busy=0, hazard=0; issue and retire on register 3 together -> busy stays 0x0008.
REQ-045 gra=1 for one cycle, then all gr* low with r_in=1 -> reg_in=0x0008, because sel_q is held.
REQ-046 Drop rst_n mid-cycle with busy=0x0208 -> busy, op and sel are 0 before the next clk edge.
